// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM mux/demux pair.
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    // Frame alignment state of the receiver.
    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demux: tracks which channel the next valid beat
// belongs to. Priority is clear > load-to-1 > increment.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              inc,
    output logic [SLOT_W-1:0] s,
    output logic              wrap
);

    // Slot register: clear on reset/lost sync, 1 after a start-of-frame beat,
    // otherwise advance on each accepted beat (wraps naturally mod 4).
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            s <= '0;
        end else if (load) begin
            s <= SLOT_W'(1);
        end else if (inc) begin
            s <= s + 1'b1;
        end
    end

    // High while the next beat is the last channel of the frame.
    assign wrap = (s == SLOT_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM demultiplexer with frame alignment tracking.
// Handshake: a beat is transferred on every rising edge where din_valid=1;
// there is no back-pressure, and sof is only meaningful on such beats.
// The FSM state is exposed directly: locked is the registered state bit.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic                    sof,
    output logic [NUM_CH*WIDTH-1:0] d,
    output logic                    frame_valid,
    output logic [SLOT_W-1:0]       s,
    output logic                    locked,
    output logic                    sync_err
);

    state_t            state;
    state_t            state_nxt;
    logic              ctr_clr;
    logic              ctr_load;
    logic              ctr_inc;
    logic              wrap;
    logic              slot0_we;
    logic              shadow_we;
    logic              frame_we;
    logic              err_nxt;
    logic [WIDTH-1:0]  shadow [NUM_CH-1];

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .load  (ctr_load),
        .inc   (ctr_inc),
        .s     (s),
        .wrap  (wrap)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-beat control decode.
    always_comb begin
        state_nxt = state;
        ctr_clr   = 1'b0;
        ctr_load  = 1'b0;
        ctr_inc   = 1'b0;
        slot0_we  = 1'b0;
        shadow_we = 1'b0;
        frame_we  = 1'b0;
        err_nxt   = 1'b0;
        if (din_valid) begin
            case (state)
                ST_HUNT: begin
                    if (sof) begin
                        ctr_load  = 1'b1;
                        slot0_we  = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sof) begin
                        // sof restarts the frame; anywhere but slot 0 it is early.
                        ctr_load = 1'b1;
                        slot0_we = 1'b1;
                        err_nxt  = (s != '0);
                    end else if (s == '0) begin
                        // Slot 0 without sof: alignment lost, drop the beat.
                        err_nxt   = 1'b1;
                        ctr_clr   = 1'b1;
                        state_nxt = ST_HUNT;
                    end else if (wrap) begin
                        frame_we = 1'b1;
                        ctr_inc  = 1'b1;
                    end else begin
                        shadow_we = 1'b1;
                        ctr_inc   = 1'b1;
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
        end
    end

    // Shadow capture, frame output register and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH - 1; k++) begin
                shadow[k] <= '0;
            end
            d           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= frame_we;
            sync_err    <= err_nxt;
            if (slot0_we) begin
                shadow[0] <= din;
            end
            for (int k = 1; k < NUM_CH - 1; k++) begin
                if (shadow_we && s == SLOT_W'(k)) begin
                    shadow[k] <= din;
                end
            end
            if (frame_we) begin
                for (int k = 0; k < NUM_CH - 1; k++) begin
                    d[k*WIDTH +: WIDTH] <= shadow[k];
                end
                d[(NUM_CH-1)*WIDTH +: WIDTH] <= din;
            end
        end
    end

    assign locked = (state == ST_RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios with literal
// expectations, then randomized traffic against a frame-queue model.
module tb_tdm_demux4;

    localparam int W  = 8;
    localparam int DW = 4 * W;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din_valid = 1'b0;
    logic          sof = 1'b0;
    logic [W-1:0]  din = '0;
    logic [DW-1:0] d;
    logic          frame_valid;
    logic [1:0]    s;
    logic          locked;
    logic          sync_err;

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .d           (d),
        .frame_valid (frame_valid),
        .s           (s),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The frame is the list of beats collected since the last sof; the slot
    // index is simply how many beats are held. Completed frames go to exp_q.
    logic [W-1:0]  frame_q[$];
    logic [DW-1:0] exp_q[$];
    logic          m_locked = 1'b0;
    logic          m_fv = 1'b0;
    logic          m_err = 1'b0;
    logic [DW-1:0] m_d = '0;
    bit            started = 1'b0;

    initial forever begin
        @(posedge clk);
        started = 1'b1;
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!rst_n) begin
            frame_q.delete();
            m_locked = 1'b0;
            m_d      = '0;
        end else if (din_valid) begin
            if (sof) begin
                if (m_locked && frame_q.size() != 0) m_err = 1'b1;
                frame_q.delete();
                frame_q.push_back(din);
                m_locked = 1'b1;
            end else if (m_locked) begin
                if (frame_q.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    frame_q.push_back(din);
                    if (frame_q.size() == 4) begin
                        m_d = '0;
                        foreach (frame_q[k]) m_d = m_d | (DW'(frame_q[k]) << (k * W));
                        m_fv = 1'b1;
                        exp_q.push_back(m_d);
                        frame_q.delete();
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("d", d, m_d);
            chk("frame_valid", DW'(frame_valid), DW'(m_fv));
            chk("s", DW'(s), DW'(frame_q.size()));
            chk("locked", DW'(locked), DW'(m_locked));
            chk("sync_err", DW'(sync_err), DW'(m_err));
            if (frame_valid) begin
                chk("frame_sb_nonempty", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) chk("frame_sb", d, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic beat(input logic [W-1:0] v, input logic f, input logic [1:0] exp_s, input string nm);
        @(negedge clk);
        din_valid = 1'b1;
        din       = v;
        sof       = f;
        @(posedge clk);
        #1;
        chk(nm, DW'(s), DW'(exp_s));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
            sof       = 1'($urandom_range(0, 1));
            din       = W'($urandom);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int tx_slot;

        // Reset held for two cycles.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_d", d, DW'(0));
        chk("rst_s", DW'(s), DW'(0));
        chk("rst_locked", DW'(locked), DW'(0));
        chk("rst_fv", DW'(frame_valid), DW'(0));
        chk("rst_err", DW'(sync_err), DW'(0));
        rst_n = 1'b1;

        // Clean frame.
        beat(8'h11, 1'b1, 2'd1, "clean_s1");
        beat(8'h22, 1'b0, 2'd2, "clean_s2");
        beat(8'h33, 1'b0, 2'd3, "clean_s3");
        beat(8'h44, 1'b0, 2'd0, "clean_s0");
        chk("clean_d", d, 32'h44332211);
        chk("clean_fv", DW'(frame_valid), DW'(1));
        idle(1);
        @(posedge clk); #1;
        chk("clean_fv_pulse", DW'(frame_valid), DW'(0));

        // HUNT discard (0xAA also breaks the lock held from the clean frame).
        beat(8'hAA, 1'b0, 2'd0, "hunt_aa_s");
        chk("hunt_aa_unlocked", DW'(locked), DW'(0));
        beat(8'hBB, 1'b0, 2'd0, "hunt_bb_s");
        chk("hunt_bb_unlocked", DW'(locked), DW'(0));
        beat(8'h01, 1'b1, 2'd1, "hunt_01_s");
        chk("hunt_locked", DW'(locked), DW'(1));
        beat(8'h02, 1'b0, 2'd2, "hunt_02_s");
        beat(8'h03, 1'b0, 2'd3, "hunt_03_s");
        beat(8'h04, 1'b0, 2'd0, "hunt_04_s");
        chk("hunt_d", d, 32'h04030201);

        // Gapped frame: d keeps 0x04030201 during gaps (per-cycle compare).
        idle(3);
        beat(8'h11, 1'b1, 2'd1, "gap_s1");
        idle(3);
        beat(8'h22, 1'b0, 2'd2, "gap_s2");
        idle(3);
        chk("gap_d_hold", d, 32'h04030201);
        beat(8'h33, 1'b0, 2'd3, "gap_s3");
        idle(3);
        beat(8'h44, 1'b0, 2'd0, "gap_s0");
        chk("gap_d", d, 32'h44332211);
        idle(2);

        // Early sof at slot 2.
        beat(8'h11, 1'b1, 2'd1, "early_s1");
        beat(8'h22, 1'b0, 2'd2, "early_s2");
        beat(8'h55, 1'b1, 2'd1, "early_restart_s");
        chk("early_err", DW'(sync_err), DW'(1));
        beat(8'h66, 1'b0, 2'd2, "early_66_s");
        chk("early_err_pulse", DW'(sync_err), DW'(0));
        beat(8'h77, 1'b0, 2'd3, "early_77_s");
        chk("early_no_update", d, 32'h44332211);
        beat(8'h88, 1'b0, 2'd0, "early_88_s");
        chk("early_d", d, 32'h88776655);

        // sof landing on slot 3 is also early.
        beat(8'hC1, 1'b1, 2'd1, "s3sof_s1");
        beat(8'hC2, 1'b0, 2'd2, "s3sof_s2");
        beat(8'hC3, 1'b0, 2'd3, "s3sof_s3");
        beat(8'hD1, 1'b1, 2'd1, "s3sof_restart");
        chk("s3sof_err", DW'(sync_err), DW'(1));
        chk("s3sof_no_fv", DW'(frame_valid), DW'(0));
        chk("s3sof_d", d, 32'h88776655);
        beat(8'hD2, 1'b0, 2'd2, "s3sof_d2");
        beat(8'hD3, 1'b0, 2'd3, "s3sof_d3");
        beat(8'hD4, 1'b0, 2'd0, "s3sof_d4");
        chk("s3sof_frame", d, 32'hD4D3D2D1);

        // Lost sync, then re-lock.
        beat(8'h99, 1'b0, 2'd0, "lost_s");
        chk("lost_err", DW'(sync_err), DW'(1));
        chk("lost_unlocked", DW'(locked), DW'(0));
        chk("lost_d_hold", d, 32'hD4D3D2D1);
        beat(8'h10, 1'b1, 2'd1, "relock_s");
        chk("relock_locked", DW'(locked), DW'(1));

        // Reset mid-frame: partial frame must never surface.
        beat(8'h20, 1'b0, 2'd2, "midrst_s2");
        @(negedge clk);
        rst_n = 1'b0; din_valid = 1'b1; din = 8'h30; sof = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_d", d, DW'(0));
        chk("midrst_locked", DW'(locked), DW'(0));
        beat(8'h40, 1'b0, 2'd0, "midrst_after_s");
        chk("midrst_no_fv", DW'(frame_valid), DW'(0));
        idle(2);

        // Randomized traffic, mostly well-framed with occasional faults.
        tx_slot = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 199) != 0);
            din_valid = ($urandom_range(0, 99) < 70);
            din       = W'($urandom);
            if (din_valid) begin
                sof = (tx_slot == 0);
                if ($urandom_range(0, 99) < 4) sof = ~sof;
                tx_slot = (tx_slot + 1) % 4;
            end else begin
                sof = 1'($urandom_range(0, 1));
            end
        end
        rst_n = 1'b1;
        idle(3);
        chk("exp_q_drained", DW'(exp_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Receive-side partner of the 4:1 channel mux: takes a time-division-multiplexed stream (one channel sample per valid beat, channel 0 flagged by `sof`) and rebuilds the four channels as parallel registered outputs. It sits after the serial link and in front of per-channel consumers. It also tracks frame alignment and flags sync loss.

## Interface
Parameters:
- `WIDTH`, default 8: bits per channel sample.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `din` in WIDTH: muxed sample for the current slot.
- `din_valid` in 1: `din`/`sof` qualify this cycle.
- `sof` in 1: start of frame, meaning this beat is channel 0. Ignored when `din_valid`=0.
- `d` out 4*WIDTH: rebuilt frame. Channel k is `d[k*WIDTH +: WIDTH]`, so channel 0 is at the LSBs.
- `frame_valid` out 1: one-cycle pulse when `d` updates.
- `s` out 2: slot index expected on the next valid beat, the inverse of the mux select.
- `locked` out 1: high in RUN state.
- `sync_err` out 1: one-cycle pulse on alignment violation.

## Operation
- **States:**
  - HUNT: unaligned. Beats without `sof` are discarded.
  - RUN: aligned.
- **HUNT:**
  - On `din_valid` && `sof`: store `din` as slot 0, set `s`=1, go to RUN.
- **RUN**, on each `din_valid` beat:
  - Slot counter `s` selects the shadow register written with `din`. `s` increments mod 4.
  - Beat in slot 3: copy shadow slots 0–2 plus the current `din` into `d` and pulse `frame_valid`. `s` wraps to 0.
  - `sof` with `s`≠0: early frame. Pulse `sync_err`, discard the partial frame (no `d` update), store `din` as slot 0, set `s`=1, stay in RUN.
  - No `sof` with `s`=0: lost sync. Pulse `sync_err`, drop the beat, go to HUNT, set `s`=0.
- `din_valid`=0: state, `s`, shadow and `d` all hold. Gaps between beats, including mid-frame gaps, are legal.
- `d` holds the last complete frame until the next complete frame arrives. Partial frames never reach `d`.
- **Reset** (`rst_n`=0 at a clock edge):
  - State HUNT, `s`=0.
  - `d`=0, `frame_valid`=0, `sync_err`=0, `locked`=0.
  - Shadow registers cleared.
  - Reset mid-frame discards the partial frame.
  - Reset dominates `din_valid` in the same cycle.

## Timing
- All outputs are registered.
- Latency: the slot-3 beat sampled at edge N gives `d` updated and `frame_valid`=1 after edge N, for exactly one cycle.
- `sync_err` is asserted for the cycle after the offending beat. It coincides with `locked`=0 when the cause was lost sync.
- `s` and `locked` update after the edge that samples the beat.
- Minimum frame time is 4 cycles, so back-to-back frames can pulse `frame_valid` every 4th cycle.
- Simultaneous `sof` and slot-3 position (`s`=3 with `sof`) counts as an early frame. No `d` update.

## Structure
- Shared package `tdm_pkg`:
  - `NUM_CH`=4.
  - `SLOT_W`=2.
  - State encoding constants `ST_HUNT`=1'b0 and `ST_RUN`=1'b1.
  - The transmitter-side mux/serializer uses the same package.
- One sub-module, `tdm_slot_ctr`. It owns:
  - the 2-bit slot counter, with increment on valid, load-to-1 on `sof`, and clear;
  - the wrap flag.
- The FSM, shadow registers and output registers stay in the top level.

## Test plan
Scenarios use WIDTH=8:
- **Reset:** hold `rst_n`=0 for 2 cycles → `d`=0, `s`=0, `locked`=0, no pulses. Assert reset mid-frame → partial frame never appears.
- **Clean frame:** valid beats 0x11(`sof`), 0x22, 0x33, 0x44 on consecutive cycles → after the 4th beat, `d`=0x44332211 and `frame_valid` high for 1 cycle; `s` sequence is 1,2,3,0.
- **Gapped frame:** the same data with `din_valid`=0 gaps of 3 cycles between beats → identical `d`, a single `frame_valid`, and `d` unchanged during the gaps.
- **HUNT discard:** beats 0xAA, 0xBB without `sof`, then 0x01(`sof`), 0x02, 0x03, 0x04 → `locked` rises after 0x01; `d`=0x04030201.
- **Early `sof`:** 0x11(`sof`), 0x22, then 0x55(`sof`), 0x66, 0x77, 0x88 → `sync_err` pulse after 0x55, no update from the first frame, then `d`=0x88776655.
- **Lost sync:** after a good frame, send 0x99 without `sof` at slot 0 → `sync_err` pulse, `locked`=0, `d` retains the previous frame, and re-lock on the next `sof`.
